// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Round-robin arbiter and sequencer in front of one shared, purely
// combinational 16-bit adder/subtractor. Requesters hand over operands
// through a valid/ready handshake. The winning operands are registered
// and drive the shared unit for one EXEC cycle. The result, carry-out
// and signed overflow are then captured and returned with a one-cycle,
// one-hot strobe tagged with the requester index.
//
// Timing: a grant in cycle t gives an EXEC cycle at t+1 and rsp_valid at
// t+2. A new grant may be issued in the same cycle as that response, so
// the sustained rate is one operation every two cycles.

module addsub_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_mode,
   output logic [WIDTH-1:0]      adder_a,
   output logic [WIDTH-1:0]      adder_b,
   output logic                  adder_mode,
   input  logic [WIDTH-1:0]      adder_sum,
   input  logic                  adder_cout,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_ovf,
   output logic                  busy
);

   // Sequencer states: IDLE arbitrates, EXEC lets the shared unit settle.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   state_t          state;
   logic [IDW-1:0]  ptr;        // highest-priority requester for the next grant
   logic [IDW-1:0]  owner;      // requester whose operands are on the adder

   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  cand;
   logic [NREQ-1:0] grant_onehot;
   logic [IDW-1:0]  next_ptr;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic            sel_mode;
   logic            ovf_next;
   logic [NREQ-1:0] done_onehot;

   // Round-robin search: walk from the pointer, wrapping at NREQ, and stop at the first valid requester.
   always_comb begin
      // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
         cand = (cand == LAST_ID) ? '0 : cand + IDW'(1);
      end
   end

   // Decode the winner to one-hot form.
   always_comb begin
      grant_onehot = '0;
      if (grant_found) begin
         grant_onehot[grant_idx] = 1'b1;
      end
   end

   // Decode the owner of the operation in EXEC to one-hot form for the response strobe.
   always_comb begin
      done_onehot        = '0;
      done_onehot[owner] = 1'b1;
   end

   // Ready is combinational and offered only in IDLE. It is held low while reset is asserted.
   assign req_ready = (state == ST_IDLE && !rst) ? grant_onehot : '0;

   // Operand select for the winner, and the pointer value that follows this grant.
   assign sel_a    = req_a[grant_idx*WIDTH +: WIDTH];
   assign sel_b    = req_b[grant_idx*WIDTH +: WIDTH];
   assign sel_mode = req_mode[grant_idx];
   assign next_ptr = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);

   // Signed overflow: operands with equal sign as seen by the adder (B already
   // inverted for subtract) that produce a sum of the opposite sign.
   assign ovf_next = (adder_a[WIDTH-1] == (adder_b[WIDTH-1] ^ adder_mode)) &&
                     (adder_sum[WIDTH-1] != adder_a[WIDTH-1]);

   // Sequencer FSM. It owns every registered output: the operand latch, the response registers and busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         owner      <= '0;
         adder_a    <= '0;
         adder_b    <= '0;
         adder_mode <= 1'b0;
         rsp_valid  <= '0;
         rsp_id     <= '0;
         rsp_sum    <= '0;
         rsp_cout   <= 1'b0;
         rsp_ovf    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
         rsp_valid <= '0;
         case (state)
            ST_IDLE: begin
               if (grant_found) begin
                  adder_a    <= sel_a;
                  adder_b    <= sel_b;
                  adder_mode <= sel_mode;
                  owner      <= grant_idx;
                  ptr        <= next_ptr;
                  busy       <= 1'b1;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_sum   <= adder_sum;
               rsp_cout  <= adder_cout;
               rsp_ovf   <= ovf_next;
               rsp_id    <= owner;
               rsp_valid <= done_onehot;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter
// Directed and randomized checks of the arbiter/sequencer. The bench plays
// the shared adder itself. A cycle-level reference model predicts the grant,
// the busy and adder operand outputs, and the tagged response, using plain
// integer arithmetic on the architectural rules.

module tb_addsub_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a = '0;
   logic [NREQ*WIDTH-1:0] req_b = '0;
   logic [NREQ-1:0]       req_mode = '0;
   logic [WIDTH-1:0]      adder_a;
   logic [WIDTH-1:0]      adder_b;
   logic                  adder_mode;
   logic [WIDTH-1:0]      adder_sum;
   logic                  adder_cout;
   logic [NREQ-1:0]       rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic                  rsp_ovf;
   logic                  busy;

   addsub_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_mode   (req_mode),
      .adder_a    (adder_a),
      .adder_b    (adder_b),
      .adder_mode (adder_mode),
      .adder_sum  (adder_sum),
      .adder_cout (adder_cout),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_ovf    (rsp_ovf),
      .busy       (busy)
   );

   // Shared combinational adder/subtractor: A + (B ^ mode) + mode.
   assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b ^ {WIDTH{adder_mode}}} + {16'b0, adder_mode};

   always #5 clk = ~clk;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model state.
   int         m_ptr  = 0;
   bit         m_exec = 1'b0;
   bit         m_rsp  = 1'b0;
   logic [15:0] m_a, m_b;
   logic        m_mode;
   logic [1:0]  m_id;
   logic [15:0] held_sum  = '0;
   logic        held_cout = 1'b0;
   logic        held_ovf  = 1'b0;
   logic [1:0]  held_id   = '0;

   int  last_grant = -1;
   bit  log_en = 1'b0;
   int  grant_log[$];
   int  rr_exp[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_asserts++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // First requester at or after p, wrapping; -1 if none.
   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[2'((p + k) % NREQ)]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [3:0] oh(input int i);
      logic [3:0] r;
      r = '0;
      r[2'(i)] = 1'b1;
      return r;
   endfunction

   // Expected {ovf, cout, sum} from integer arithmetic.
   function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic m);
      int ua, ub, sa, sb, full, sres;
      logic c;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (m) begin
         full = ua - ub;
         c    = (ua >= ub);
         sres = sa - sb;
      end else begin
         full = ua + ub;
         c    = (full > 65535);
         sres = sa + sb;
      end
      return {(sres > 32767 || sres < -32768), c, full[15:0]};
   endfunction

   // Compare every observable output against the model for the current cycle.
   task automatic check_now();
      int g;
      logic [3:0] exp_ready;
      logic [3:0] exp_rv;
      #1;
      exp_ready = '0;
      if (!m_exec) begin
         g = pick(req_valid, m_ptr);
         if (g >= 0) exp_ready = oh(g);
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_exec));
      if (m_exec) begin
         chk("adder_ab", {adder_a, adder_b}, {m_a, m_b});
         chk("adder_mode", 32'(adder_mode), 32'(m_mode));
      end
      exp_rv = m_rsp ? oh(int'(held_id)) : 4'b0;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_fields", 32'({rsp_id, rsp_cout, rsp_ovf, rsp_sum}),
          32'({held_id, held_cout, held_ovf, held_sum}));
   endtask

   // Advance one clock and step the model; ends on the falling edge.
   task automatic tick();
      int g;
      logic [17:0] res;
      g = m_exec ? -1 : pick(req_valid, m_ptr);
      last_grant = -1;
      for (int k = 0; k < NREQ; k++) begin
         if (req_ready[k]) last_grant = k;
      end
      if (log_en && last_grant >= 0) grant_log.push_back(last_grant);
      @(posedge clk);
      if (m_exec) begin
         m_exec    = 1'b0;
         m_rsp     = 1'b1;
         res       = ref_op(m_a, m_b, m_mode);
         held_sum  = res[15:0];
         held_cout = res[16];
         held_ovf  = res[17];
         held_id   = m_id;
      end else begin
         m_rsp = 1'b0;
         if (g >= 0) begin
            m_a    = req_a[g*WIDTH +: WIDTH];
            m_b    = req_b[g*WIDTH +: WIDTH];
            m_mode = req_mode[g];
            m_id   = 2'(g);
            m_ptr  = (g + 1) % NREQ;
            m_exec = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Assert reset asynchronously, check the cleared outputs, hold two cycles, release.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_ctl", 32'({req_ready, rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy, adder_mode}), 32'h0);
      chk("rst_sum", 32'(rsp_sum), 32'h0);
      chk("rst_adder", {adder_a, adder_b}, 32'h0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         chk("rst_hold", 32'({req_ready, rsp_valid, busy}), 32'h0);
      end
      rst       = 1'b0;
      m_ptr     = 0;
      m_exec    = 1'b0;
      m_rsp     = 1'b0;
      held_sum  = '0;
      held_cout = 1'b0;
      held_ovf  = 1'b0;
      held_id   = '0;
   endtask

   task automatic set_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic m);
      req_a[idx*WIDTH +: WIDTH] = a;
      req_b[idx*WIDTH +: WIDTH] = b;
      req_mode[idx]             = m;
   endtask

   // One isolated operation with the response checked against hand-computed constants.
   task automatic single_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic m,
                            input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
      set_op(idx, a, b, m);
      req_valid = oh(idx);
      check_now();
      chk("grant_t", 32'(req_ready), 32'(oh(idx)));
      tick();
      req_valid = '0;
      check_now();
      tick();
      check_now();
      chk("rsp_valid_t2", 32'(rsp_valid), 32'(oh(idx)));
      chk("rsp_sum_const", 32'(rsp_sum), 32'(e_sum));
      chk("rsp_flags_const", 32'({rsp_id, rsp_cout, rsp_ovf}), 32'({2'(idx), e_cout, e_ovf}));
      tick();
   endtask

   function automatic logic [15:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #2;
      do_reset();

      // Arithmetic corner cases.
      single_op(0, 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0);
      single_op(2, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      single_op(2, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
      single_op(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      single_op(3, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      single_op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Round robin with all four requesting from reset, then requester 1 drops out.
      for (int i = 0; i < NREQ; i++) set_op(i, 16'(i * 16'h0111), 16'(i + 1), 1'(i % 2));
      req_valid = 4'hF;
      do_reset();
      grant_log.delete();
      log_en = 1'b1;
      for (int c = 0; c < 12; c++) begin
         check_now();
         tick();
      end
      req_valid[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         check_now();
         tick();
      end
      log_en = 1'b0;
      chk("rr_count", 32'(grant_log.size()), 32'd10);
      for (int i = 0; i < 10 && i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(rr_exp[i]));

      // Pointer wrap: requester 3 alone, then 0 beats 3 after 3 was served.
      req_valid = '0;
      do_reset();
      req_valid = 4'b1000;
      check_now();
      chk("sparse_g3", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'b1001;
      check_now();
      tick();
      check_now();
      chk("wrap_g0", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      repeat (3) begin
         check_now();
         tick();
      end

      // Reset in the middle of EXEC drops the operation.
      set_op(2, 16'h4444, 16'h1111, 1'b0);
      req_valid = 4'b0100;
      check_now();
      tick();
      req_valid = 4'b1010;
      chk("busy_before_rst", 32'(busy), 32'h1);
      do_reset();
      check_now();
      chk("post_rst_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      repeat (4) begin
         check_now();
         tick();
      end

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (last_grant == i || !req_valid[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               set_op(i, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         check_now();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit structural adder/subtractor instance among NREQ requesters.
- Accepts operand/mode requests over a valid/ready handshake and drives the shared unit from registered operands.
- Captures sum, carry-out and signed overflow, and returns a one-cycle tagged response.
- Sits between client blocks and the single Sub_adder_16bit datapath, which stays purely combinational.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width; must match the shared adder.
- IDW, 2, width of grant/response ID (ceil log2 NREQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  one-hot grant; a transfer occurs when valid&ready.
- req_a  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- req_mode  input  NREQ  0 = add, 1 = subtract (A-B).
- adder_a  output  WIDTH  to shared adder a.
- adder_b  output  WIDTH  to shared adder b.
- adder_mode  output  1  to shared adder mode.
- adder_sum  input  WIDTH  from shared adder sum.
- adder_cout  input  1  from shared adder cout.
- rsp_valid  output  NREQ  one-hot, one-cycle result strobe to the owning requester.
- rsp_id  output  IDW  index of the requester being answered.
- rsp_sum  output  WIDTH  registered result.
- rsp_cout  output  1  registered carry-out (subtract: 1 = no borrow, A>=B unsigned).
- rsp_ovf  output  1  registered two's-complement overflow.
- busy  output  1  high while an operation is in EXEC.

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE and the round-robin pointer returns to 0.
  - All outputs clear to 0: req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy, adder_a, adder_b, adder_mode.
- Reset mid-operation:
  - The in-flight operation is dropped.
  - No rsp_valid is produced for it.
- FSM state IDLE:
  - If any req_valid is high, grant exactly one requester: the first set bit at or after the pointer, wrapping modulo NREQ.
  - req_ready[g] is asserted combinationally in this cycle only.
  - On that edge: latch a, b, mode and g; set pointer = (g+1) mod NREQ; go to EXEC.
  - If no request is pending: stay in IDLE and leave the pointer unchanged.
- FSM state EXEC (exactly one cycle):
  - adder_a/adder_b/adder_mode are driven from the latched operands (held stable during EXEC and after it until the next grant).
  - busy = 1 and req_ready = 0.
  - At the end of EXEC, register rsp_sum = adder_sum, rsp_cout = adder_cout, rsp_id = g.
  - Also register rsp_ovf = (A[W-1] == Bx[W-1]) && (adder_sum[W-1] != A[W-1]), where Bx = B ^ {WIDTH{mode}}.
  - Next state is IDLE.
- Response timing:
  - rsp_valid[g] is high for exactly the first IDLE cycle after EXEC, i.e. grant at cycle t gives a response at cycle t+2.
  - rsp_sum/rsp_cout/rsp_ovf/rsp_id hold until the next response.
  - No response backpressure exists.
- Throughput:
  - One operation per 2 cycles.
  - A new grant may occur in the same cycle as a rsp_valid.
- Requester rules:
  - Operands must be stable while valid is high and ready is low.
  - valid may drop before grant; an ungranted request is simply forgotten.
  - A requester may re-request in the same cycle its response arrives.
- Fairness: under continuous requests from all k requesters, each is granted once every k grants.
- Arithmetic:
  - Width is modulo 2^WIDTH.
  - Subtraction is performed by the shared unit (1's complement plus cin = mode); this block never modifies operands.

Test Plan:
- Single add: req0 A=0x1234, B=0x0FF0, mode=0.
  - req_ready[0] at t; rsp_valid[0] at t+2.
  - rsp_sum=0x2224, cout=0, ovf=0, rsp_id=0.
- Subtract/borrow: req2 A=0x0003, B=0x0005, mode=1.
  - rsp_sum=0xFFFE, cout=0, ovf=0.
  - Repeat with A=0x0005, B=0x0003: sum=0x0002, cout=1.
- Overflow: add 0x7FFF+0x0001 gives sum 0x8000, ovf=1, cout=0.
  - Subtract 0x8000-0x0001 gives sum 0x7FFF, ovf=1, cout=1.
  - Add 0xFFFF+0x0001 gives sum 0x0000, cout=1, ovf=0.
- Round-robin: all 4 valid continuously from reset.
  - Grants in order 0,1,2,3,0,1 at cycles t, t+2, t+4, ...
  - Drop req1 mid-run: order skips 1 (…3,0,2,3…).
- Pointer wrap / sparse:
  - Only req3 then req0 pending: grants 3 then 0.
  - After granting 3 with req0 and req3 both pending, 0 wins next.
- Async reset mid-EXEC: assert rst during busy.
  - All outputs 0 immediately; no rsp_valid afterwards.
  - First post-reset grant goes to the lowest pending index.
